// File: rtl/status_display_scanner.sv
// Two-digit multiplexed 7-segment status display: input glitch filter, scan FSM with blanking gaps.
// Optional macro DISPLAY_ALARM_BLINK_EN: alarm blinks the display instead of lighting the decimal point.
module status_display_scanner #(
  parameter int REFRESH_DIV   = 50000,
  parameter int STABLE_CYCLES = 4,
  parameter int BLINK_DIV     = 12500000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] encoded_water,
  input  logic [1:0] encoded_irrigation,
  input  logic       alarm,
  output logic [6:0] segments,
  output logic       decimal_point,
  output logic [1:0] digit_enable
);

  localparam int DW = $clog2(REFRESH_DIV + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] STAB_MAX   = SW'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    SHOW_WATER = 2'd0,
    BLANK_A    = 2'd1,
    SHOW_IRRIG = 2'd2,
    BLANK_B    = 2'd3
  } scan_state_e;

  function automatic logic [6:0] water_glyph(input logic [1:0] code);
    case (code)
      2'd0:    return 7'h40;
      2'd1:    return 7'h79;
      2'd2:    return 7'h24;
      default: return 7'h30;
    endcase
  endfunction

  function automatic logic [6:0] irrig_glyph(input logic [1:0] code);
    case (code)
      2'd0:    return 7'h3F;
      2'd1:    return 7'h12;
      2'd2:    return 7'h21;
      default: return 7'h06;
    endcase
  endfunction

  // Bundle layout: [4] alarm, [3:2] water, [1:0] irrigation
  logic [4:0]    w_bundle;
  logic [4:0]    r_cand;
  logic [4:0]    r_commit;
  logic [SW-1:0] r_stab_cnt;
  logic [SW-1:0] w_stab_next;
  logic          w_match;
  logic          w_commit_now;

  assign w_bundle = {alarm, encoded_water, encoded_irrigation};

  // Commit lands on the same edge the counter reaches STABLE_CYCLES.
  always_comb begin
    w_match      = (w_bundle == r_cand);
    w_stab_next  = (r_stab_cnt == STAB_MAX) ? r_stab_cnt : r_stab_cnt + SW'(1);
    w_commit_now = w_match && (w_stab_next == STAB_MAX);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cand     <= '0;
      r_stab_cnt <= '0;
      r_commit   <= '0;
    end else begin
      if (!w_match) begin
        r_cand     <= w_bundle;
        r_stab_cnt <= '0;
      end else begin
        r_stab_cnt <= w_stab_next;
      end
      if (w_commit_now) r_commit <= r_cand;
    end
  end

  scan_state_e   r_state;
  scan_state_e   w_state_next;
  logic [DW-1:0] r_dwell;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SHOW_WATER;
      r_dwell <= '0;
    end else begin
      r_state <= w_state_next;
      r_dwell <= (w_state_next != r_state) ? '0 : r_dwell + DW'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SHOW_WATER: if (r_dwell == DWELL_LAST) w_state_next = BLANK_A;
      BLANK_A:    w_state_next = SHOW_IRRIG;
      SHOW_IRRIG: if (r_dwell == DWELL_LAST) w_state_next = BLANK_B;
      default:    w_state_next = SHOW_WATER;
    endcase
  end

  logic w_alarm_dark;

`ifdef DISPLAY_ALARM_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic          w_alarm_rise;

  // A fresh alarm restarts the blink so the visible half comes first.
  assign w_alarm_rise = w_commit_now && r_cand[4] && !r_commit[4];
  assign w_alarm_dark = r_commit[4] && r_blink_phase;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_alarm_rise) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + BW'(1);
    end
  end
`else
  assign w_alarm_dark = 1'b0;
`endif

  logic [6:0] w_seg;
  logic [1:0] w_de;
  logic       w_dp;

  // NOTE: defaults first so no path through this block leaves an output unassigned (no latch).
  always_comb begin
    w_seg = 7'h7F;
    w_de  = 2'b11;
    w_dp  = 1'b1;
    case (r_state)
      SHOW_WATER: begin
        w_de  = 2'b10;
        w_seg = w_alarm_dark ? 7'h7F : water_glyph(r_commit[3:2]);
`ifndef DISPLAY_ALARM_BLINK_EN
        w_dp  = ~r_commit[4];
`endif
      end
      SHOW_IRRIG: begin
        w_de  = 2'b01;
        w_seg = w_alarm_dark ? 7'h7F : irrig_glyph(r_commit[1:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      segments      <= 7'h7F;
      decimal_point <= 1'b1;
      digit_enable  <= 2'b11;
    end else begin
      segments      <= w_seg;
      decimal_point <= w_dp;
      digit_enable  <= w_de;
    end
  end

endmodule
